barrier_arbiter: RTL and testbench
==================================

// Module: barrier_arbiter
// PURPOSE
//  Arbitrates one shared boom barrier between the entry request (ticket button) and the exit
//  request (exit reader). Sequences the barrier motor: raise, hold open, lower.
//  Closes on the car-passed pulse from fsm_sensores, or on a timeout.
//  Gates entry on lleno and exit on vacio, both from contador_estacionamiento.
//  Sits beside the sensor FSM and the counter in top_estacionamiento.
// PARAMETERS
//  RAISE_CYCLES  50_000_000  cycles motor_up is held (1..2^TMR_W-1)
//  PASS_TIMEOUT  500_000_000 max cycles in OPEN waiting for the pass pulse (1..2^TMR_W-1)
//  CLOSE_CYCLES  50_000_000  cycles motor_down is held (1..2^TMR_W-1)
//  TMR_W         32          timer width
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  req_in     in   1  entry request (level, clean)
//  req_out    in   1  exit request (level, clean)
//  lleno      in   1  lot full; blocks entry grants
//  vacio      in   1  lot empty; blocks exit grants
//  auto_entra in   1  1-cycle pulse: car entered
//  auto_sale  in   1  1-cycle pulse: car left
//  obstruct   in   1  beam under barrier blocked
//  grant_in   out  1  entry lane owns barrier
//  grant_out  out  1  exit lane owns barrier
//  motor_up   out  1  raise drive
//  motor_down out  1  lower drive
//  gate_open  out  1  barrier fully open
//  timeout    out  1  1-cycle pulse: OPEN expired without a pass
// BEHAVIOUR
//  - Single clock, synchronous active-high reset. Reset forces state IDLE, all outputs 0, timer 0,
//    last_grant=OUT (so the first contention goes to entry) and pending bits 0. Reset mid-motion
//    drops both motor outputs on the next edge.
//  - States: IDLE -> RAISING -> OPEN -> LOWERING -> IDLE. All outputs are registered.
//  - IDLE: eligible_in = req_in & ~lleno; eligible_out = req_out & ~vacio.
//    - If exactly one is eligible, that lane is granted.
//    - If both are eligible, grant the lane opposite last_grant (round robin).
//    - A grant decided at edge n gives state RAISING at edge n+1, with grant_x=1, motor_up=1 and
//      the timer loaded with RAISE_CYCLES-1. last_grant is updated.
//  - RAISING: the timer counts to 0, so motor_up is high for exactly RAISE_CYCLES cycles.
//    Then go to OPEN with gate_open=1 and the timer loaded with PASS_TIMEOUT-1.
//  - OPEN: the matching pulse goes to LOWERING (auto_entra if grant_in, auto_sale if grant_out).
//    - A wrong-direction pulse is ignored.
//    - On timer expiry, pulse timeout for 1 cycle and go to LOWERING.
//    - gate_open drops on LOWERING entry.
//  - LOWERING: motor_down is high for CLOSE_CYCLES cycles, then IDLE. grant_x clears on IDLE entry.
//    If obstruct=1 in any LOWERING cycle, go back to RAISING on the next edge with a full
//    RAISE_CYCLES reload. The grant is kept.
//  - obstruct is ignored outside LOWERING.
//  - Invariants: grant_in & grant_out == 0; motor_up & motor_down == 0.
//  - Requests arriving outside IDLE are not served until IDLE. lleno/vacio are sampled only at the
//    IDLE grant decision.
// CONFIGURATION
//  - BARRIER_REQ_LATCH_EN defined:
//    - A 1-cycle req pulse sets pend_in/pend_out in any state.
//    - Eligibility uses (req | pend).
//    - Pending bits clear when their lane is granted, and on reset.
//    - pend_in is kept while lleno=1 and is served once lleno=0.
//  - BARRIER_REQ_LATCH_EN undefined: requests are level-sampled only in IDLE; no pending registers.
// STRUCTURE
//  - barrier_pkg.vh: state encodings (ST_IDLE, ST_RAISING, ST_OPEN, ST_LOWERING, 2 bits),
//    lane codes LANE_IN/LANE_OUT, parameter defaults.
//  - Sub-module barrier_timer (TMR_W): load value, load strobe, count-down enable, zero flag.
//    One instance, reused by all timed states.
// TESTING  (bench: RAISE_CYCLES=4, PASS_TIMEOUT=10, CLOSE_CYCLES=3)
//  1. req_in=1 held, lleno=0 -> grant_in at edge+1; motor_up 4 cycles; gate_open; auto_entra
//     -> motor_down 3 cycles -> IDLE, grant_in=0.
//  2. req_in=req_out=1 together, lleno=vacio=0, after reset -> entry first; held -> exit
//     granted next.
//  3. req_in=1, lleno=1 -> no grant, outputs stay 0; req_out=1, vacio=1 -> no grant.
//  4. Granted, no pass pulse -> timeout pulses once exactly 10 cycles after OPEN entry, then
//     LOWERING.
//  5. obstruct=1 in 2nd LOWERING cycle -> RAISING next edge, motor_up 4 cycles, grant held.
//  6. Reset asserted mid-OPEN -> next edge all outputs 0, IDLE; latch build: a 1-cycle req_out
//     during OPEN is served after LOWERING.

Source files
------------

// File: rtl/barrier_pkg.sv
// Shared encodings and defaults for the boom barrier arbiter.
package barrier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAISING  = 2'd1,
        ST_OPEN     = 2'd2,
        ST_LOWERING = 2'd3
    } state_t;

    typedef enum logic {
        LANE_IN  = 1'b0,
        LANE_OUT = 1'b1
    } lane_t;

    localparam int unsigned DEF_RAISE_CYCLES = 50_000_000;
    localparam int unsigned DEF_PASS_TIMEOUT = 500_000_000;
    localparam int unsigned DEF_CLOSE_CYCLES = 50_000_000;
    localparam int unsigned DEF_TMR_W        = 32;

endpackage

// File: rtl/barrier_timer.sv
// Down-counter shared by every timed barrier state; load wins over counting.
module barrier_timer #(
    parameter int unsigned TMR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/barrier_arbiter.sv
// Shared barrier arbiter: round-robin entry/exit grant, raise/open/lower sequencing.
// Optional request latching is enabled by defining BARRIER_REQ_LATCH_EN.
module barrier_arbiter
    import barrier_pkg::*;
#(
    parameter int unsigned RAISE_CYCLES = DEF_RAISE_CYCLES,
    parameter int unsigned PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int unsigned TMR_W        = DEF_TMR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic req_in,
    input  logic req_out,
    input  logic lleno,
    input  logic vacio,
    input  logic auto_entra,
    input  logic auto_sale,
    input  logic obstruct,
    output logic grant_in,
    output logic grant_out,
    output logic motor_up,
    output logic motor_down,
    output logic gate_open,
    output logic timeout
);

    localparam logic [TMR_W-1:0] RAISE_LD = TMR_W'(RAISE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PASS_LD  = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CLOSE_LD = TMR_W'(CLOSE_CYCLES - 1);

    state_t           state;
    lane_t            last_grant;
    lane_t            pick;
    logic             req_in_eff, req_out_eff;
    logic             elig_in, elig_out, any_elig;
    logic             pass_evt;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0] tmr_ld_val;

`ifdef BARRIER_REQ_LATCH_EN
    logic pend_in, pend_out;
    logic take_in, take_out;

    assign take_in  = (state == ST_IDLE) && any_elig && (pick == LANE_IN);
    assign take_out = (state == ST_IDLE) && any_elig && (pick == LANE_OUT);

    // A grant clears its pending bit even if the request is still asserted that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_in  <= 1'b0;
            pend_out <= 1'b0;
        end else begin
            pend_in  <= (pend_in  | req_in)  & ~take_in;
            pend_out <= (pend_out | req_out) & ~take_out;
        end
    end

    assign req_in_eff  = req_in  | pend_in;
    assign req_out_eff = req_out | pend_out;
`else
    assign req_in_eff  = req_in;
    assign req_out_eff = req_out;
`endif

    assign elig_in  = req_in_eff  & ~lleno;
    assign elig_out = req_out_eff & ~vacio;
    assign any_elig = elig_in | elig_out;
    assign pass_evt = (grant_in & auto_entra) | (grant_out & auto_sale);

    always_comb begin
        if (elig_in && elig_out)
            pick = (last_grant == LANE_OUT) ? LANE_IN : LANE_OUT;
        else
            pick = elig_in ? LANE_IN : LANE_OUT;
    end

    // Timer reload points mirror the FSM transitions below.
    always_comb begin
        tmr_load   = 1'b0;
        tmr_ld_val = RAISE_LD;
        case (state)
            ST_IDLE:     tmr_load = any_elig;
            ST_RAISING: begin
                tmr_load   = tmr_zero;
                tmr_ld_val = PASS_LD;
            end
            ST_OPEN: begin
                tmr_load   = pass_evt | tmr_zero;
                tmr_ld_val = CLOSE_LD;
            end
            ST_LOWERING: tmr_load = obstruct;
            default:     tmr_load = 1'b0;
        endcase
    end

    assign tmr_en = (state != ST_IDLE);

    barrier_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= LANE_OUT;
            grant_in   <= 1'b0;
            grant_out  <= 1'b0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            gate_open  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        state      <= ST_RAISING;
                        grant_in   <= (pick == LANE_IN);
                        grant_out  <= (pick == LANE_OUT);
                        motor_up   <= 1'b1;
                        last_grant <= pick;
                    end
                end
                ST_RAISING: begin
                    if (tmr_zero) begin
                        state     <= ST_OPEN;
                        motor_up  <= 1'b0;
                        gate_open <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    // A pass in the expiry cycle counts as a pass, not a timeout.
                    if (pass_evt || tmr_zero) begin
                        state      <= ST_LOWERING;
                        gate_open  <= 1'b0;
                        motor_down <= 1'b1;
                        timeout    <= ~pass_evt;
                    end
                end
                ST_LOWERING: begin
                    if (obstruct) begin
                        state      <= ST_RAISING;
                        motor_down <= 1'b0;
                        motor_up   <= 1'b1;
                    end else if (tmr_zero) begin
                        state      <= ST_IDLE;
                        motor_down <= 1'b0;
                        grant_in   <= 1'b0;
                        grant_out  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrier_arbiter.sv
// Directed bench for barrier_arbiter with short timing parameters.
module tb_barrier_arbiter;

    logic clk = 1'b0;
    logic reset, req_in, req_out, lleno, vacio, auto_entra, auto_sale, obstruct;
    logic grant_in, grant_out, motor_up, motor_down, gate_open, timeout;
    int   n_pass = 0;
    int   n_tot  = 0;

    // Output vector order: grant_in grant_out motor_up motor_down gate_open timeout
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] I_RAISE  = 6'b101000;
    localparam logic [5:0] I_OPEN   = 6'b100010;
    localparam logic [5:0] I_LOWER  = 6'b100100;
    localparam logic [5:0] X_RAISE  = 6'b011000;
    localparam logic [5:0] X_OPEN   = 6'b010010;
    localparam logic [5:0] X_LOWER  = 6'b010100;
    localparam logic [5:0] X_LOW_TO = 6'b010101;

    barrier_arbiter #(
        .RAISE_CYCLES(4),
        .PASS_TIMEOUT(10),
        .CLOSE_CYCLES(3),
        .TMR_W(32)
    ) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out),
        .lleno(lleno), .vacio(vacio), .auto_entra(auto_entra), .auto_sale(auto_sale),
        .obstruct(obstruct), .grant_in(grant_in), .grant_out(grant_out),
        .motor_up(motor_up), .motor_down(motor_down), .gate_open(gate_open),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {grant_in, grant_out, motor_up, motor_down, gate_open, timeout};
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        n_tot++;
        assert (!(grant_in && grant_out) && !(motor_up && motor_down)) n_pass++;
        else $error("FAIL %s_overlap observed=%b expected=no grant/motor overlap", tag, obs);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_in = 0; req_out = 0; lleno = 0; vacio = 0;
        auto_entra = 0; auto_sale = 0; obstruct = 0;
        cyc(1);
        do_reset();
        chk("reset_state", O_IDLE);

        // 1: entry transaction, wrong-direction pulse ignored
        req_in = 1; cyc(1); req_in = 0;
        for (int k = 0; k < 4; k++) begin chk("t1_raise", I_RAISE); cyc(1); end
        chk("t1_open", I_OPEN);
        auto_sale = 1; cyc(1); auto_sale = 0;
        chk("t1_wrong_pulse", I_OPEN);
        auto_entra = 1; cyc(1); auto_entra = 0;
        for (int k = 0; k < 3; k++) begin chk("t1_lower", I_LOWER); cyc(1); end
        chk("t1_idle", O_IDLE);

        // 2: contention after reset: entry first, then exit
        do_reset();
        req_in = 1; req_out = 1; cyc(1);
        chk("t2_first_in", I_RAISE);
        cyc(4); chk("t2_open_in", I_OPEN);
        auto_entra = 1; cyc(1); auto_entra = 0;
        cyc(3); chk("t2_idle_gap", O_IDLE);
        cyc(1); chk("t2_second_out", X_RAISE);
        req_in = 0; req_out = 0;
        cyc(4); chk("t2_open_out", X_OPEN);
        auto_sale = 1; cyc(1); auto_sale = 0;
        chk("t2_lower_out", X_LOWER);
        cyc(3); chk("t2_idle", O_IDLE);

        // 3: lleno / vacio block grants
        lleno = 1; req_in = 1; cyc(3);
        chk("t3_lleno_block", O_IDLE);
        req_in = 0; lleno = 0; vacio = 1; req_out = 1; cyc(3);
        chk("t3_vacio_block", O_IDLE);
        req_out = 0; vacio = 0;
        do_reset();

        // 4: timeout exactly 10 cycles after OPEN entry
        req_out = 1; cyc(1); req_out = 0;
        chk("t4_grant_out", X_RAISE);
        cyc(4); chk("t4_open", X_OPEN);
        cyc(9); chk("t4_pre_timeout", X_OPEN);
        cyc(1); chk("t4_timeout", X_LOW_TO);
        cyc(1); chk("t4_timeout_once", X_LOWER);

        // 5: obstruct in 2nd LOWERING cycle re-raises, grant held
        obstruct = 1; cyc(1); obstruct = 0;
        for (int k = 0; k < 4; k++) begin chk("t5_reraise", X_RAISE); cyc(1); end
        chk("t5_reopen", X_OPEN);

        // 6: request during OPEN, then reset mid-OPEN
        req_out = 1; cyc(1); req_out = 0;
        auto_sale = 1; cyc(1); auto_sale = 0;
        chk("t6_lower", X_LOWER);
        cyc(3); chk("t6_idle", O_IDLE);
        cyc(1);
`ifdef BARRIER_REQ_LATCH_EN
        chk("t6_latched_out", X_RAISE);
        cyc(4); chk("t6_open", X_OPEN);
`else
        chk("t6_no_latch", O_IDLE);
        req_in = 1; cyc(1); req_in = 0;
        cyc(4); chk("t6_open", I_OPEN);
`endif
        reset = 1'b1; cyc(1);
        chk("t6_reset_mid_open", O_IDLE);
        reset = 1'b0; cyc(2);
        chk("t6_after_reset", O_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
